// File: rtl/regfile_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_pkg: shared widths, XZR default and arbitration pointer type  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package regfile_pkg;

  localparam int REG_W       = 5;
  localparam int DATA_W      = 64;
  localparam int XZR_DEFAULT = 31;

  // Pointer records the requester granted most recently.
  typedef enum logic {
    PTR_R0 = 1'b0,
    PTR_R1 = 1'b1
  } ptr_e;

  function automatic logic is_commit(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] xzr);
    return dst != xzr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_wr_arbiter_if: two writeback requesters plus regfile port     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface regfile_wr_arbiter_if #(
  parameter int CNT_W = 16
);
  import regfile_pkg::*;

  logic                req0_valid;
  logic [REG_W-1:0]    req0_reg;
  logic [DATA_W-1:0]   req0_data;
  logic                req0_ready;

  logic                req1_valid;
  logic [REG_W-1:0]    req1_reg;
  logic [DATA_W-1:0]   req1_data;
  logic                req1_ready;

  logic                RegWrite;
  logic [REG_W-1:0]    WriteRegister;
  logic [DATA_W-1:0]   WriteData;
  logic [CNT_W-1:0]    wr_count;

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    input  RegWrite, WriteRegister, WriteData, wr_count
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    output RegWrite, WriteRegister, WriteData, wr_count
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arb2: two-input round-robin grant, favouring the non-last winner   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  ptr_e       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == PTR_R0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_wr_arbiter: round-robin merge of two writeback streams onto   |
// | the single regfile write port, one-cycle registered. Rev 1.0          |
// +-----------------------------------------------------------------------+
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int XZR_INDEX = XZR_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [REG_W-1:0] c_xzr_reg = REG_W'(XZR_INDEX);

  ptr_e               r_ptr;
  ptr_e               w_ptr_next;
  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_xfer;
  logic               w_commit;
  logic [REG_W-1:0]   w_sel_reg;
  logic [DATA_W-1:0]  w_sel_data;

  logic               r_wr_en;
  logic [REG_W-1:0]   r_wr_reg;
  logic [DATA_W-1:0]  r_wr_data;
  logic [CNT_W-1:0]   r_count;

  // Reset masks requests so no handshake can complete while it is held.
  assign w_req = {bus.req1_valid, bus.req0_valid} & {2{~reset}};

  rr_arb2 u_arb (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_ptr_next = r_ptr;
    w_xfer     = |w_gnt;
    w_sel_reg  = bus.req0_reg;
    w_sel_data = bus.req0_data;
    if (w_gnt[1]) begin
      w_sel_reg  = bus.req1_reg;
      w_sel_data = bus.req1_data;
    end
    w_commit = w_xfer && is_commit(w_sel_reg, c_xzr_reg);
    if (w_gnt[0]) begin
      w_ptr_next = PTR_R0;
    end else if (w_gnt[1]) begin
      w_ptr_next = PTR_R1;
    end
  end

  // Pointer starts at R1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= PTR_R1;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_count   <= '0;
    end else begin
      r_wr_en <= w_commit;
      if (w_xfer) begin
        r_wr_reg  <= w_sel_reg;
        r_wr_data <= w_sel_data;
      end
      if (w_commit) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];

  // Gating by reset squashes a write captured just before reset asserted.
  assign bus.RegWrite      = r_wr_en & ~reset;
  assign bus.WriteRegister = r_wr_reg;
  assign bus.WriteData     = r_wr_data;
  assign bus.wr_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_regfile_wr_arbiter: directed self-checking bench for the arbiter   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_regfile_wr_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [63:0] rf [32];

  regfile_wr_arbiter_if #(.CNT_W(16)) bus ();

  regfile_wr_arbiter #(
    .XZR_INDEX (31),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream 32x64 register file fed by the write port.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) rf[k] <= '0;
    end else if (bus.RegWrite) begin
      rf[bus.WriteRegister] <= bus.WriteData;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic        g;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] exp_d;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
    tick(); tick();

    // Requests during reset are never granted
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    chk("rst_rdy1", bus.req1_ready, 1'b0);
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    chk("rst_regwrite", bus.RegWrite, 1'b0);
    chk("rst_wreg", bus.WriteRegister, 5'd0);
    chk("rst_wdata", bus.WriteData, 64'd0);
    chk("rst_count", bus.wr_count, 16'd0);
    tick();
    chk("rst_no_xfer", bus.RegWrite, 1'b0);

    // Single requester 0: same-cycle grant, write next cycle
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd5; bus.req0_data = 64'hA5;
    #1;
    chk("single_rdy0", bus.req0_ready, 1'b1);
    chk("single_rdy1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    chk("single_regwrite", bus.RegWrite, 1'b1);
    chk("single_wreg", bus.WriteRegister, 5'd5);
    chk("single_wdata", bus.WriteData, 64'hA5);
    chk("single_count", bus.wr_count, 16'd1);
    tick();
    chk("idle_regwrite", bus.RegWrite, 1'b0);
    chk("idle_hold_wreg", bus.WriteRegister, 5'd5);
    chk("idle_hold_wdata", bus.WriteData, 64'hA5);
    tick();

    // Idle cycles keep pointer: last winner r0, so r1 wins contest
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd6; bus.req0_data = 64'h66;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd8; bus.req1_data = 64'h88;
    #1;
    chk("ptr_hold_rdy1", bus.req1_ready, 1'b1);
    chk("ptr_hold_rdy0", bus.req0_ready, 1'b0);
    tick();
    bus.req1_valid = 1'b0;
    chk("ptr_hold_wreg", bus.WriteRegister, 5'd8);
    #1;
    chk("ptr_hold_rdy0_next", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    chk("ptr_hold_wreg2", bus.WriteRegister, 5'd6);
    chk("ptr_hold_count", bus.wr_count, 16'd3);

    // Contest right after reset: r0 first, then r1
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd1; bus.req0_data = 64'h11;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd2; bus.req1_data = 64'h22;
    #1;
    chk("dual_rdy0", bus.req0_ready, 1'b1);
    chk("dual_rdy1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    chk("dual_w1_en", bus.RegWrite, 1'b1);
    chk("dual_w1_reg", bus.WriteRegister, 5'd1);
    chk("dual_w1_data", bus.WriteData, 64'h11);
    chk("dual_w1_count", bus.wr_count, 16'd1);
    #1;
    chk("dual_rdy1_next", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    chk("dual_w2_en", bus.RegWrite, 1'b1);
    chk("dual_w2_reg", bus.WriteRegister, 5'd2);
    chk("dual_w2_data", bus.WriteData, 64'h22);
    chk("dual_w2_count", bus.wr_count, 16'd2);
    tick();
    chk("dual_rf_x1", rf[1], 64'h11);
    chk("dual_rf_x2", rf[2], 64'h22);

    // Sustained contest for 8 cycles: strict alternation
    do_reset();
    d0 = 64'h100; d1 = 64'h200;
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd3; bus.req0_data = d0;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd4; bus.req1_data = d1;
    for (int i = 0; i < 8; i++) begin
      g = (i % 2) == 1;
      exp_d = g ? d1 : d0;
      #1;
      chk($sformatf("alt%0d_rdy0", i), bus.req0_ready, !g);
      chk($sformatf("alt%0d_rdy1", i), bus.req1_ready, g);
      tick();
      chk($sformatf("alt%0d_en", i), bus.RegWrite, 1'b1);
      chk($sformatf("alt%0d_reg", i), bus.WriteRegister, g ? 5'd4 : 5'd3);
      chk($sformatf("alt%0d_data", i), bus.WriteData, exp_d);
      if (g) begin
        d1 = d1 + 1; bus.req1_data = d1;
      end else begin
        d0 = d0 + 1; bus.req0_data = d0;
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("alt_count", bus.wr_count, 16'd8);
    tick();
    chk("alt_end_en", bus.RegWrite, 1'b0);
    chk("alt_rf_x3", rf[3], 64'h103);
    chk("alt_rf_x4", rf[4], 64'h203);

    // Write to XZR: handshake completes, nothing committed
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd31; bus.req1_data = 64'hFF;
    #1;
    chk("xzr_rdy1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    chk("xzr_en", bus.RegWrite, 1'b0);
    chk("xzr_count", bus.wr_count, 16'd8);
    tick();
    chk("xzr_rf_x31", rf[31], 64'd0);

    // Transfer immediately followed by reset is squashed
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd7; bus.req0_data = 64'h77;
    #1;
    chk("sq_rdy0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("sq_en_rst", bus.RegWrite, 1'b0);
    tick();
    chk("sq_en_after", bus.RegWrite, 1'b0);
    chk("sq_count", bus.wr_count, 16'd0);
    reset = 1'b0;
    tick();
    chk("sq_en_post", bus.RegWrite, 1'b0);
    chk("sq_rf_x7", rf[7], 64'd0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req1_reg = 5'd9; bus.req1_data = 64'h99;
    #1;
    chk("sq_contest_rdy0", bus.req0_ready, 1'b1);
    chk("sq_contest_rdy1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("sq_contest_reg", bus.WriteRegister, 5'd7);

    // Counter wrap: drive it to 0xFFFF with back-to-back commits
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd9; bus.req0_data = 64'h99;
    repeat (65535) tick();
    chk("wrap_ffff", bus.wr_count, 16'hFFFF);
    tick();
    bus.req0_valid = 1'b0;
    chk("wrap_zero", bus.wr_count, 16'h0000);
    chk("wrap_en", bus.RegWrite, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL take parameter XZR_INDEX, default 31, the register index whose writes are accepted but never committed.
REQ-002 The block SHALL take parameter CNT_W, default 16, the width of the committed-write counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req0_valid, input, 1 bit: requester 0 (ALU writeback) has a write pending.
REQ-006 Port req0_reg, input, 5 bits: destination register index for requester 0.
REQ-007 Port req0_data, input, 64 bits: write data for requester 0.
REQ-008 Port req0_ready, output, 1 bit: requester 0's write is accepted this cycle.
REQ-009 Ports req1_valid, req1_reg, req1_data and req1_ready SHALL mirror REQ-005..008 for requester 1 (memory load return).
REQ-010 Port RegWrite, output, 1 bit: write enable to the register file.
REQ-011 Port WriteRegister, output, 5 bits: register file write index.
REQ-012 Port WriteData, output, 64 bits: register file write data.
REQ-013 Port wr_count, output, CNT_W bits: number of writes committed to the register file.

Function
REQ-014 A transfer SHALL occur on requester i in any cycle where reqi_valid and reqi_ready are both 1.
REQ-015 reqi_ready SHALL be a combinational function of both valids and the round-robin pointer, and SHALL NOT be 1 when reqi_valid is 0.
REQ-016 At most one ready SHALL be 1 per cycle.
REQ-017 If exactly one requester is valid, that requester SHALL be granted in the same cycle.
REQ-018 If both requesters are valid, the requester not granted most recently (per the pointer) SHALL be granted.
REQ-019 The pointer SHALL update only on a transfer and SHALL record the granted requester; idle cycles SHALL leave it unchanged.
REQ-020 A requester SHALL hold valid, reg and data stable until it transfers; the block SHALL sample reg and data only in the transfer cycle.
REQ-021 A transfer in cycle N SHALL drive RegWrite=1, WriteRegister=reg and WriteData=data during cycle N+1 only (registered, one-cycle latency).
REQ-022 A transfer whose reg equals XZR_INDEX SHALL complete the handshake but SHALL leave RegWrite=0 in cycle N+1 and SHALL NOT increment wr_count.
REQ-023 With no transfer in cycle N, RegWrite SHALL be 0 in cycle N+1; WriteRegister and WriteData SHALL hold their previous values.
REQ-024 wr_count SHALL increment by 1 in the same edge that sets RegWrite=1 and SHALL wrap modulo 2^CNT_W with no saturation.
REQ-025 Sustained dual requests SHALL alternate grants, with no requester waiting more than one cycle once valid.
REQ-026 Back-to-back transfers SHALL be accepted every cycle, giving full write-port throughput.

Reset
REQ-027 While reset is 1, req0_ready and req1_ready SHALL be 0 and no transfer SHALL occur.
REQ-028 On the edge where reset is sampled 1: RegWrite, WriteRegister, WriteData and wr_count SHALL become 0, and the pointer SHALL be set so that requester 0 wins the first contested grant.
REQ-029 A transfer accepted in the cycle before reset asserts SHALL be squashed: RegWrite SHALL be 0 in the following cycle.

Structure
REQ-030 Shared package regfile_pkg SHALL hold the register index width (5), data width (64), the XZR default (31) and the grant/pointer enum.
REQ-031 The two-input round-robin grant logic SHALL be one sub-module, rr_arb2, with inputs req[1:0], ptr and outputs gnt[1:0].
REQ-032 The block SHALL drive the existing 32x64 register file write port directly, with no added latency.

Verification
REQ-033 Only req0 valid (reg=5, data=0xA5) in cycle 1 -> req0_ready=1 in cycle 1; RegWrite=1, WriteRegister=5, WriteData=0xA5 in cycle 2; wr_count=1.
REQ-034 Both valid right after reset (r0 reg=1/data=0x11, r1 reg=2/data=0x22), held -> grants r0 then r1 on consecutive cycles; regfile writes to x1 then x2; wr_count=2.
REQ-035 Both valid continuously for 8 cycles with new data per transfer -> grants strictly alternate; 8 consecutive RegWrite pulses; wr_count=8.
REQ-036 req1 write to reg=31 with data=0xFF -> req1_ready=1; RegWrite stays 0; wr_count unchanged; a subsequent read of x31 is unchanged.
REQ-037 Transfer in cycle N with reset=1 in cycle N+1 -> RegWrite=0 in N+1 and after; wr_count=0; next contested grant goes to r0.
REQ-038 Preload wr_count to 0xFFFF, then one commit -> wr_count=0x0000.
